ps2_rx: RTL and testbench

- PS/2 device-to-host receiver. It is the receive-side companion to the host transmitter on the same ps2c/ps2d pins.
- Filters the PS/2 clock, samples data on filtered falling edges and deframes 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Delivers each byte with a one-cycle valid strobe and error flags to the keyboard/mouse decode logic.
- Receives only while enabled. Upper logic deasserts rx_en_i while the transmitter owns the bus.

---
 rtl/ps2_rx_if.sv | 23 ++
 rtl/ps2_rx.sv | 160 ++++++++++++++++
 tb/tb_ps2_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Receive-side bundle between the PS/2 pins, the receiver and the keyboard/mouse decoder.
// master = decode logic and pin drivers, slave = the ps2_rx receiver.
`timescale 1ns/1ps
interface ps2_rx_if;
    logic       rx_en_i;
    logic       ps2c_i;
    logic       ps2d_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       idle_o;

    modport master (
        output rx_en_i, ps2c_i, ps2d_i,
        input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o, idle_o
    );

    modport slave (
        input  rx_en_i, ps2c_i, ps2d_i,
        output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, idle_o
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters ps2c, samples ps2d on
// filtered falling edges and deframes start/8 data/odd parity/stop into a byte strobe.
`timescale 1ns/1ps
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    ps2_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    state_e                state_q, state_d;
    logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_shift_q, filt_shift_d;
    logic                  filt_q, filt_d;
    logic                  fall, timeout;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;

    // Conditioning chain resets to the idle-high bus level so reset release never looks like an edge.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            c_meta_q     <= 1'b1;
            c_sync_q     <= 1'b1;
            d_meta_q     <= 1'b1;
            d_sync_q     <= 1'b1;
            filt_shift_q <= '1;
            filt_q       <= 1'b1;
        end else begin
            c_meta_q     <= bus.ps2c_i;
            c_sync_q     <= c_meta_q;
            d_meta_q     <= bus.ps2d_i;
            d_sync_q     <= d_meta_q;
            filt_shift_q <= filt_shift_d;
            filt_q       <= filt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        filt_shift_d = {filt_shift_q[FILTER_LEN-2:0], c_sync_q};
        filt_d       = filt_q;
        if (filt_shift_q == '1)      filt_d = 1'b1;
        else if (filt_shift_q == '0) filt_d = 1'b0;
    end

    assign fall    = filt_q & ~filt_d;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Abort on rx_en_i has priority, then a fall, and only then the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fall && bus.rx_en_i && !d_sync_q) state_d = S_DATA;
            end
            S_DATA: begin
                if (!bus.rx_en_i)  state_d = S_IDLE;
                else if (fall)     state_d = (bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
                else if (timeout)  state_d = S_IDLE;
            end
            S_PARITY: begin
                if (!bus.rx_en_i)  state_d = S_IDLE;
                else if (fall)     state_d = S_STOP;
                else if (timeout)  state_d = S_IDLE;
            end
            S_STOP: begin
                if (!bus.rx_en_i || fall || timeout) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        cnt_d        = (state_d == S_IDLE || fall) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (fall && bus.rx_en_i && !d_sync_q) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (bus.rx_en_i) begin
                    if (fall) begin
                        if (state_q == S_DATA) begin
                            shift_d   = {d_sync_q, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end else if (state_q == S_PARITY) begin
                            par_d = d_sync_q;
                        end else if (d_sync_q) begin
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shift_q;
                            parity_err_d = ~(^{shift_q, par_q});
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (timeout) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        bus.idle_o       = (state_q == S_IDLE);
        bus.rx_data_o    = rx_data_q;
        bus.rx_valid_o   = rx_valid_q;
        bus.parity_err_o = parity_err_q;
        bus.frame_err_o  = frame_err_q;
    end
endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of whole frames plus hand sequences for timeout, glitches,
// enable abort and mid-frame reset; strobes are checked against a queue of expected events.
`timescale 1ns/1ps
module tb_ps2_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 10000;
    localparam int HALF           = 200;   // 40 us PS/2 half-period at a 200 ns clk_i

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;

    ps2_rx_if bus ();

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #100 clk_i = ~clk_i;

    typedef struct {
        logic fe;
        logic [7:0] data;
        logic perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       exp_fe;
        logic       exp_perr;
    } vec_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         strobes;
    int         strobe_cyc;
    int         last_fall_cyc;
    logic [7:0] m_data;
    logic       m_perr;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (reset_ni && (bus.rx_valid_o || bus.frame_err_o)) begin
            strobes++;
            strobe_cyc = cyc;
            check("valid_frame_err_exclusive", 32'(bus.rx_valid_o & bus.frame_err_o), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_is_frame_err", 32'(bus.frame_err_o), 32'(e.fe));
                check("rx_data", 32'(bus.rx_data_o), 32'(e.data));
                check("parity_err", 32'(bus.parity_err_o), 32'(e.perr));
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk_i);
        bus.ps2d_i = b;
        repeat (HALF / 2) @(negedge clk_i);
        bus.ps2c_i    = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk_i);
        bus.ps2c_i = 1'b1;
        repeat (HALF / 2) @(negedge clk_i);
    endtask

    task automatic glitch();
        @(negedge clk_i);
        bus.ps2c_i = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk_i);
        bus.ps2c_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                              input int n_bits, input int glitch_at);
        logic [10:0] bits;
        bits = {stop, (~^data) ^ par_flip, data, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            ps2_bit(bits[i]);
            if (i == glitch_at) begin
                glitch();
                repeat (HALF) @(negedge clk_i);
            end
        end
        bus.ps2d_i = 1'b1;
    endtask

    task automatic expect_valid(input logic [7:0] data, input logic perr);
        sb.push_back('{fe: 1'b0, data: data, perr: perr});
        m_data = data;
        m_perr = perr;
    endtask

    task automatic finish_frame(input string name, input int exp_strobes);
        repeat (40) @(negedge clk_i);
        check({name, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        strobes = 0;
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{data: 8'h1C, par_flip: 1'b0, stop: 1'b1, exp_fe: 1'b0, exp_perr: 1'b0};
        vecs[1] = '{data: 8'hF0, par_flip: 1'b1, stop: 1'b1, exp_fe: 1'b0, exp_perr: 1'b1};
        vecs[2] = '{data: 8'h5A, par_flip: 1'b0, stop: 1'b0, exp_fe: 1'b1, exp_perr: 1'b1};
        vecs[3] = '{data: 8'h00, par_flip: 1'b0, stop: 1'b1, exp_fe: 1'b0, exp_perr: 1'b0};
        vecs[4] = '{data: 8'hFF, par_flip: 1'b1, stop: 1'b1, exp_fe: 1'b0, exp_perr: 1'b1};

        bus.rx_en_i = 1'b1;
        bus.ps2c_i  = 1'b1;
        bus.ps2d_i  = 1'b1;
        strobes     = 0;
        m_data      = 8'h00;
        m_perr      = 1'b0;
        repeat (5) @(negedge clk_i);
        check("reset_rx_data", 32'(bus.rx_data_o), 32'h00);
        check("reset_rx_valid", 32'(bus.rx_valid_o), 32'd0);
        check("reset_parity_err", 32'(bus.parity_err_o), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err_o), 32'd0);
        check("reset_idle", 32'(bus.idle_o), 32'd1);
        reset_ni = 1'b1;
        repeat (20) @(negedge clk_i);

        // Table of whole frames; frame errors keep the previous byte and parity flag.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].exp_fe) sb.push_back('{fe: 1'b1, data: m_data, perr: m_perr});
            else                expect_valid(vecs[i].data, vecs[i].exp_perr);
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, 11, -1);
            if (i == 0) check("stop_fall_latency", 32'(strobe_cyc - last_fall_cyc), 32'(FILTER_LEN + 3));
            finish_frame("table", 1);
        end

        // Three falls, then silence: frame error TIMEOUT_CYCLES after the last fall is seen.
        sb.push_back('{fe: 1'b1, data: m_data, perr: m_perr});
        send_frame(8'h29, 1'b0, 1'b1, 3, -1);
        repeat (TIMEOUT_CYCLES) @(negedge clk_i);
        check("timeout_delay", 32'(strobe_cyc - last_fall_cyc), 32'(TIMEOUT_CYCLES + FILTER_LEN + 3));
        check("timeout_idle", 32'(bus.idle_o), 32'd1);
        finish_frame("timeout", 1);
        expect_valid(8'h29, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        finish_frame("after_timeout", 1);

        // Short clock glitches in IDLE and mid-frame must be swallowed by the filter.
        glitch();
        repeat (20) @(negedge clk_i);
        check("glitch_idle_state", 32'(bus.idle_o), 32'd1);
        expect_valid(8'hAA, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 11, 3);
        finish_frame("glitch_frame", 1);

        // Enable dropped after 4 data bits; a frame sent while disabled is ignored.
        send_frame(8'h77, 1'b0, 1'b1, 5, -1);
        check("abort_busy", 32'(bus.idle_o), 32'd0);
        bus.rx_en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("abort_idle", 32'(bus.idle_o), 32'd1);
        send_frame(8'h33, 1'b0, 1'b1, 11, -1);
        check("disabled_idle", 32'(bus.idle_o), 32'd1);
        bus.rx_en_i = 1'b1;
        finish_frame("disabled", 0);
        expect_valid(8'h12, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1, 11, -1);
        finish_frame("after_abort", 1);
        check("after_abort_data", 32'(bus.rx_data_o), 32'h12);

        // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
        send_frame(8'h45, 1'b0, 1'b1, 4, -1);
        @(negedge clk_i);
        #20;
        reset_ni = 1'b0;
        #1;
        check("midreset_rx_data", 32'(bus.rx_data_o), 32'h00);
        check("midreset_idle", 32'(bus.idle_o), 32'd1);
        check("midreset_valid", 32'(bus.rx_valid_o), 32'd0);
        check("midreset_frame_err", 32'(bus.frame_err_o), 32'd0);
        m_data = 8'h00;
        m_perr = 1'b0;
        repeat (5) @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        expect_valid(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 11, -1);
        finish_frame("after_reset", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
